dest_scoreboard: RTL
====================

// Module: dest_scoreboard
// PURPOSE
//  Issue-stage scoreboard and register-file write-port arbiter for the 6-bit destination path.
//  - Tracks busy destination registers and stalls issue on RAW/WAW hazards.
//  - Drives the rt/rd select control of the destination selector.
//  - Shares the single register-file write port between the ALU (wb0) and MEM (wb1) writebacks.
// PARAMETERS
//  ADDR_W  6         register address width
//  NREG    64        register count (2**ADDR_W); register 0 is never busy
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  flush         in   1       synchronous flush of scoreboard state
//  issue_valid   in   1       instruction presented for issue
//  issue_ready   out  1       issue accepted this cycle (combinational)
//  src_a         in   6       source register A
//  src_b         in   6       source register B
//  src_b_used    in   1       src_b is read by the instruction
//  dest_rt       in   6       rt-field destination candidate
//  dest_rd       in   6       rd-field destination candidate
//  dest_sel_rd   in   1       0: destination = rt, 1: destination = rd
//  dest_wr       in   1       instruction writes a register
//  issued_valid  out  1       registered: an instruction issued last cycle
//  issued_dest   out  6       registered: selected destination of that instruction
//  dest_sel      out  1       registered: select control for the destination selector
//  wb0_valid     in   1       ALU writeback request
//  wb0_addr      in   6       ALU writeback register
//  wb0_ready     out  1       ALU request granted (combinational)
//  wb1_valid     in   1       MEM writeback request
//  wb1_addr      in   6       MEM writeback register
//  wb1_ready     out  1       MEM request granted (combinational)
//  rf_we         out  1       registered register-file write enable
//  rf_waddr      out  6       registered write address
//  rf_wsrc       out  1       registered: 0 = ALU data, 1 = MEM data
//  pend_count    out  7       outstanding busy registers (0..63)
//  wb_err        out  1       sticky: writeback to a non-busy, nonzero register
// BEHAVIOUR
//  Reset (async, rst_n = 0)
//  - busy[63:0] = 0; all registered outputs = 0; pend_count = 0; wb_err = 0.
//  - Round-robin pointer = "wb1 last granted", so wb0 wins the first tie.
//  Destination and hazard
//  - dest = dest_sel_rd ? dest_rd : dest_rt.
//  - hazard = busy[src_a] | (src_b_used & busy[src_b]) | (dest_wr & busy[dest]).
//  - busy[0] reads as 0 at all times.
//  - issue_ready = !hazard & !flush. fire = issue_valid & issue_ready.
//  - No same-cycle bypass: a register cleared this cycle still stalls issue this cycle.
//  Issue (on fire)
//  - busy[dest] sets at the next edge when dest_wr = 1 and dest != 0.
//  - issued_valid <= fire; issued_dest <= dest; dest_sel <= dest_sel_rd; 1-cycle latency.
//  - When fire = 0: issued_valid <= 0; issued_dest and dest_sel hold.
//  Writeback arbiter
//  - At most one grant per cycle.
//  - Only one request valid: that request is granted.
//  - Both valid: the requester not granted last is granted; the pointer updates only on a grant.
//  - Grant: busy[addr] clears at the edge; rf_we <= 1, rf_waddr <= addr, rf_wsrc <= source.
//    Write latency is 1 cycle. rf_we <= 0 when there is no grant.
//  - Granted addr 0: the rf write still occurs; no busy change; no error.
//  - Granted addr != 0 with busy[addr] = 0: wb_err <= 1 (sticky until reset); rf write still occurs.
//  Simultaneous events
//  - Set and clear of the same bit in one cycle cannot occur, because issue requires !busy[dest].
//  - pend_count: +1 on a busy set, -1 on a busy clear, unchanged when both happen.
//    It never wraps; it equals popcount(busy) at all times.
//  Flush
//  - flush = 1: busy <= 0 and pend_count <= 0 at the edge; issue is blocked.
//  - Writeback grants proceed and write the rf, but neither clear busy nor raise wb_err.
//  - The arbiter pointer holds its value.
//  Reset mid-operation
//  - All state returns to reset values immediately; in-flight grants are dropped.
// TESTING
//  - Reset, then issue with dest_sel_rd=1, dest_rd=5, dest_wr=1 ->
//    next cycle issued_dest=5, dest_sel=1, busy[5]=1, pend_count=1.
//  - With r5 busy, issue src_a=5 -> issue_ready=0. wb0 addr=5 granted ->
//    rf_we=1, rf_waddr=5, rf_wsrc=0 one cycle later; issue accepted the cycle after the clear.
//  - wb0 and wb1 valid for 4 cycles, addrs 3 and 4 busy -> grants alternate wb0, wb1, wb0, wb1;
//    pend_count decrements by 1 per grant.
//  - Issue dest=0 with dest_wr=1 -> no busy set, pend_count unchanged.
//    wb1 addr=9 with r9 not busy -> wb_err=1 and stays 1.
//  - Three registers busy, flush=1 -> pend_count=0 next cycle, issue_ready=0 during flush,
//    a concurrent wb0 grant still writes the rf.
//  - rst_n low for a few ns mid-issue (between edges) -> all outputs and busy=0 immediately,
//    without waiting for a clock edge.

Source files
------------

// File: rtl/dest_scoreboard.sv
// Issue-stage destination scoreboard: RAW/WAW stall, rt/rd select register, and a
// round-robin arbiter sharing the single register-file write port between ALU and MEM.
module dest_scoreboard #(
    parameter int ADDR_W = 6,
    parameter int NREG   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic              src_b_used,
    input  logic [ADDR_W-1:0] dest_rt,
    input  logic [ADDR_W-1:0] dest_rd,
    input  logic              dest_sel_rd,
    input  logic              dest_wr,
    output logic              issued_valid,
    output logic [ADDR_W-1:0] issued_dest,
    output logic              dest_sel,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    output logic              wb1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_wsrc,
    output logic [ADDR_W:0]   pend_count,
    output logic              wb_err
);

    localparam logic [NREG-1:0] ONE_HOT = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_v;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic              last_wb1;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] gaddr;
    logic              hazard;
    logic              fire;
    logic              grant0;
    logic              grant1;
    logic              any_grant;
    logic              set_en;
    logic              clr_en;
    logic              err_en;
    logic [ADDR_W:0]   pend_nxt;

    // Register 0 is hard-wired idle so it can never stall issue or be cleared.
    assign busy_v = busy & ~ONE_HOT;

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        dest        = dest_sel_rd ? dest_rd : dest_rt;
        hazard      = busy_v[src_a] | (src_b_used & busy_v[src_b]) | (dest_wr & busy_v[dest]);
        issue_ready = ~hazard & ~flush;
        fire        = issue_valid & issue_ready;

        // last_wb1 = 1 means wb1 won the previous tie-capable grant, so wb0 goes next.
        grant0    = wb0_valid & (~wb1_valid | last_wb1);
        grant1    = wb1_valid & (~wb0_valid | ~last_wb1);
        any_grant = grant0 | grant1;
        gaddr     = grant1 ? wb1_addr : wb0_addr;

        set_en = fire & dest_wr & (dest != '0);
        clr_en = any_grant & ~flush & busy_v[gaddr];
        err_en = any_grant & ~flush & (gaddr != '0) & ~busy_v[gaddr];

        set_mask = set_en ? (ONE_HOT << dest) : '0;
        clr_mask = clr_en ? (ONE_HOT << gaddr) : '0;

        // Set and clear never hit the same bit: issue needs the bit idle, clear needs it busy.
        pend_nxt = pend_count;
        if (flush) begin
            pend_nxt = '0;
        end else if (set_en && !clr_en) begin
            pend_nxt = pend_count + CNT_ONE;
        end else if (clr_en && !set_en) begin
            pend_nxt = pend_count - CNT_ONE;
        end
    end

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            last_wb1     <= 1'b1;
            pend_count   <= '0;
            wb_err       <= 1'b0;
            issued_valid <= 1'b0;
            issued_dest  <= '0;
            dest_sel     <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wsrc      <= 1'b0;
        end else begin
            busy       <= flush ? '0 : ((busy | set_mask) & ~clr_mask);
            pend_count <= pend_nxt;
            if (err_en) begin
                wb_err <= 1'b1;
            end
            if (any_grant && !flush) begin
                last_wb1 <= grant1;
            end

            issued_valid <= fire;
            if (fire) begin
                issued_dest <= dest;
                dest_sel    <= dest_sel_rd;
            end

            rf_we <= any_grant;
            if (any_grant) begin
                rf_waddr <= gaddr;
                rf_wsrc  <= grant1;
            end
        end
    end

endmodule
